// File: rtl/output_port_arbiter.sv
// rtl/output_port_arbiter.sv - round-robin wormhole arbiter for one router output port
module output_port_arbiter #(
    parameter int N_PORTS = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_PORTS-1:0] req,
    input  logic [N_PORTS-1:0] tail,
    input  logic               out_ready,
    output logic [N_PORTS-1:0] grant,
    output logic               grant_valid,
    output logic [2:0]         sel,
    output logic               xfer,
    output logic               pkt_done
);

    localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [PW-1:0]        own_q, own_d;
    logic [PW-1:0]        pick_idx;
    logic                 pick_found;
    logic [N_PORTS-1:0]   grant_d;
    logic [2:0]           sel_d;
    logic                 gv_d;

    // Circular search from ptr: first pass covers ptr..N-1, second pass wraps to 0..ptr-1.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int j = 0; j < N_PORTS; j++) begin
            if (!pick_found && (PW'(j) >= ptr_q) && req[j]) begin
                pick_found = 1'b1;
                pick_idx   = PW'(j);
            end
        end
        for (int j = 0; j < N_PORTS; j++) begin
            if (!pick_found && req[j]) begin
                pick_found = 1'b1;
                pick_idx   = PW'(j);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            own_q       <= '0;
            grant       <= '0;
            sel         <= '0;
            grant_valid <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            own_q       <= own_d;
            grant       <= grant_d;
            sel         <= sel_d;
            grant_valid <= gv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        grant_d = grant;
        sel_d   = sel;
        gv_d    = grant_valid;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = BUSY;
                    own_d   = pick_idx;
                    for (int j = 0; j < N_PORTS; j++) begin
                        grant_d[j] = (PW'(j) == pick_idx);
                    end
                    sel_d   = 3'(pick_idx) + 3'd1;
                    gv_d    = 1'b1;
                end
            end
            BUSY: begin
                // Ownership survives bubbles and stalls; only the tail releases it.
                if (pkt_done) begin
                    state_d = IDLE;
                    ptr_d   = (own_q == PW'(N_PORTS - 1)) ? '0 : own_q + 1'b1;
                    grant_d = '0;
                    sel_d   = 3'd0;
                    gv_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        xfer     = (|(grant & req)) & out_ready;
        pkt_done = xfer & (|(grant & tail));
    end

endmodule

// File: tb/tb_output_port_arbiter.sv
// tb/tb_output_port_arbiter.sv - scoreboard bench for output_port_arbiter
module tb_output_port_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] req;
    logic [4:0] tail;
    logic       out_ready;
    logic [4:0] grant;
    logic       grant_valid;
    logic [2:0] sel;
    logic       xfer;
    logic       pkt_done;

    typedef struct packed {
        logic [4:0] g;
        logic [2:0] s;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_vec = 0;
    int   n_err = 0;

    output_port_arbiter #(.N_PORTS(5)) dut (
        .clk(clk), .rst(rst), .req(req), .tail(tail), .out_ready(out_ready),
        .grant(grant), .grant_valid(grant_valid), .sel(sel),
        .xfer(xfer), .pkt_done(pkt_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; tail = '0; out_ready = 1'b1;
        step(); step();
        n_vec++;
        if (grant !== 5'b0 || sel !== 3'd0 || grant_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: grant=%b sel=%0d gv=%b, required 00000/0/0", grant, sel, grant_valid);
        end
        rst = 1'b0;
        step();
        n_vec++;
        if (grant !== 5'b0 || xfer !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: grant=%b xfer=%b, required 00000/0", grant, xfer);
        end
    endtask

    task automatic test_round_robin();
        int last_cyc = -1;
        req = 5'b11111; tail = 5'b11111; out_ready = 1'b1;
        exp_q.push_back('{5'b00001, 3'd1});
        exp_q.push_back('{5'b00010, 3'd2});
        exp_q.push_back('{5'b00100, 3'd3});
        exp_q.push_back('{5'b01000, 3'd4});
        exp_q.push_back('{5'b10000, 3'd5});
        exp_q.push_back('{5'b00001, 3'd1});
        for (int c = 0; c < 20; c++) begin
            step();
            if (grant_valid) begin
                e = exp_q.pop_front();
                n_vec++;
                if (grant !== e.g || sel !== e.s) begin
                    n_err++;
                    $display("FAIL rr_grant: grant=%b sel=%0d, required %b/%0d", grant, sel, e.g, e.s);
                end
                #1;
                n_vec++;
                if (pkt_done !== 1'b1) begin
                    n_err++;
                    $display("FAIL rr_pkt_done: pkt_done=%b, required 1", pkt_done);
                end
                if (last_cyc >= 0) begin
                    n_vec++;
                    if (c - last_cyc != 2) begin
                        n_err++;
                        $display("FAIL rr_spacing: %0d cycles between grants, required 2", c - last_cyc);
                    end
                end
                last_cyc = c;
                if (exp_q.size() == 0) break;
            end
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL rr_timeout: %0d grants outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        step();
        req = '0; tail = '0;
        step();
    endtask

    task automatic test_wormhole();
        logic [4:0] reqs [6]  = '{5'b01001, 5'b01001, 5'b00001, 5'b00001, 5'b01001, 5'b01001};
        logic [4:0] tails[6]  = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b01000};
        logic       exp_x[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic       exp_pd[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        req = 5'b01001; tail = '0;
        exp_q.push_back('{5'b01000, 3'd4});
        step();
        e = exp_q.pop_front();
        n_vec++;
        if (grant !== e.g || sel !== e.s) begin
            n_err++;
            $display("FAIL wh_grant: grant=%b sel=%0d, required %b/%0d", grant, sel, e.g, e.s);
        end
        for (int k = 0; k < 6; k++) begin
            req = reqs[k]; tail = tails[k];
            #1;
            n_vec++;
            if (grant !== 5'b01000 || xfer !== exp_x[k] || pkt_done !== exp_pd[k]) begin
                n_err++;
                $display("FAIL wh_cycle%0d: grant=%b xfer=%b pkt_done=%b, required 01000/%b/%b",
                         k, grant, xfer, pkt_done, exp_x[k], exp_pd[k]);
            end
            step();
        end
        n_vec++;
        if (grant !== 5'b0 || grant_valid !== 1'b0 || sel !== 3'd0) begin
            n_err++;
            $display("FAIL wh_release: grant=%b gv=%b sel=%0d, required 00000/0/0", grant, grant_valid, sel);
        end
        req = 5'b00001; tail = 5'b00001;
        exp_q.push_back('{5'b00001, 3'd1});
        step();
        e = exp_q.pop_front();
        n_vec++;
        if (grant !== e.g || sel !== e.s) begin
            n_err++;
            $display("FAIL wh_next_grant: grant=%b sel=%0d, required %b/%0d", grant, sel, e.g, e.s);
        end
        step();
        req = '0; tail = '0;
    endtask

    task automatic test_backpressure();
        req = 5'b00010; tail = 5'b00010; out_ready = 1'b1;
        exp_q.push_back('{5'b00010, 3'd2});
        step();
        e = exp_q.pop_front();
        n_vec++;
        if (grant !== e.g || sel !== e.s) begin
            n_err++;
            $display("FAIL bp_grant: grant=%b sel=%0d, required %b/%0d", grant, sel, e.g, e.s);
        end
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_vec++;
            if (xfer !== 1'b0 || pkt_done !== 1'b0 || grant !== 5'b00010) begin
                n_err++;
                $display("FAIL bp_stall%0d: xfer=%b pkt_done=%b grant=%b, required 0/0/00010", k, xfer, pkt_done, grant);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        n_vec++;
        if (xfer !== 1'b1 || pkt_done !== 1'b1) begin
            n_err++;
            $display("FAIL bp_done: xfer=%b pkt_done=%b, required 1/1", xfer, pkt_done);
        end
        step();
        req = '0; tail = '0;
        n_vec++;
        if (grant !== 5'b0) begin
            n_err++;
            $display("FAIL bp_release: grant=%b, required 00000", grant);
        end
    endtask

    task automatic test_ptr_wrap();
        req = 5'b10000; tail = 5'b10000;
        exp_q.push_back('{5'b10000, 3'd5});
        step();
        e = exp_q.pop_front();
        n_vec++;
        if (grant !== e.g || sel !== e.s) begin
            n_err++;
            $display("FAIL wrap_owner4: grant=%b sel=%0d, required %b/%0d", grant, sel, e.g, e.s);
        end
        step();
        req = 5'b10001; tail = '0;
        exp_q.push_back('{5'b00001, 3'd1});
        step();
        e = exp_q.pop_front();
        n_vec++;
        if (grant !== e.g || sel !== e.s) begin
            n_err++;
            $display("FAIL wrap_next: grant=%b sel=%0d, required %b/%0d", grant, sel, e.g, e.s);
        end
        tail = 5'b00001;
        step();
        req = '0; tail = '0;
    endtask

    task automatic test_idle();
        req = '0; tail = '0;
        for (int k = 0; k < 10; k++) begin
            step();
            n_vec++;
            if (grant !== 5'b0 || grant_valid !== 1'b0 || xfer !== 1'b0) begin
                n_err++;
                $display("FAIL idle%0d: grant=%b gv=%b xfer=%b, required 00000/0/0", k, grant, grant_valid, xfer);
            end
        end
        req = 5'b11111; tail = 5'b00000;
        exp_q.push_back('{5'b00010, 3'd2});
        step();
        e = exp_q.pop_front();
        n_vec++;
        if (grant !== e.g || sel !== e.s) begin
            n_err++;
            $display("FAIL idle_ptr_kept: grant=%b sel=%0d, required %b/%0d", grant, sel, e.g, e.s);
        end
        tail = 5'b00010;
        step();
        req = '0; tail = '0;
    endtask

    task automatic test_reset_mid_packet();
        req = 5'b00100; tail = '0;
        exp_q.push_back('{5'b00100, 3'd3});
        step();
        e = exp_q.pop_front();
        n_vec++;
        if (grant !== e.g || sel !== e.s) begin
            n_err++;
            $display("FAIL rstmid_grant: grant=%b sel=%0d, required %b/%0d", grant, sel, e.g, e.s);
        end
        step(); step();
        #1;
        rst = 1'b1;
        #1;
        n_vec++;
        if (grant !== 5'b0 || sel !== 3'd0 || grant_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_async: grant=%b sel=%0d gv=%b, required 00000/0/0", grant, sel, grant_valid);
        end
        step();
        rst = 1'b0; req = 5'b11111;
        exp_q.push_back('{5'b00001, 3'd1});
        step();
        e = exp_q.pop_front();
        n_vec++;
        if (grant !== e.g || sel !== e.s) begin
            n_err++;
            $display("FAIL rstmid_regrant: grant=%b sel=%0d, required %b/%0d", grant, sel, e.g, e.s);
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_wormhole();
        test_backpressure();
        test_ptr_wrap();
        test_idle();
        test_reset_mid_packet();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
